// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word framer.
//   SPI_BYTE_W          : width of one byte on the SPI byte-stage interface
//   DEFAULT_WORD_BYTES  : default number of payload bytes per framed word
//   framer_state_e      : 2-bit framer FSM state encoding
package spi_pkg;

  localparam int unsigned SPI_BYTE_W         = 8;
  localparam int unsigned DEFAULT_WORD_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_DONE    = 2'd3
  } framer_state_e;

endpackage

// File: rtl/spi_word_framer.sv
// Frames a multi-byte word into a sequence of byte transfers on an external
// SPI byte stage, MSB byte first, and assembles the bytes returned on MISO
// into a word (first received byte in the MSB).
//
// Ports
//   i_Clk, i_Rst_L     : clock, asynchronous active-low reset
//   i_Word, i_Word_DV  : word to send and its valid request
//   o_Word_Ready       : high while a new word can be accepted (IDLE)
//   o_Word, o_Word_DV  : received word and its one-cycle valid pulse
//   o_Busy             : high while a frame is in progress
//   o_TX_Byte, o_TX_DV : byte and byte-valid pulse to the byte stage
//   i_TX_Ready         : byte stage can accept a byte
//   i_RX_DV, i_RX_Byte : byte received by the byte stage
//   i_Cmd              : header byte, only used with the header option
//
// Build option
//   SPI_FRAMER_HDR_EN : send i_Cmd as an extra first byte; the byte received
//                       during that header transfer is discarded.
module spi_word_framer
  import spi_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst_L,
  input  logic [SPI_BYTE_W*WORD_BYTES-1:0] i_Word,
  input  logic                             i_Word_DV,
  output logic                             o_Word_Ready,
  output logic [SPI_BYTE_W*WORD_BYTES-1:0] o_Word,
  output logic                             o_Word_DV,
  output logic                             o_Busy,
  output logic [SPI_BYTE_W-1:0]            o_TX_Byte,
  output logic                             o_TX_DV,
  input  logic                             i_TX_Ready,
  input  logic                             i_RX_DV,
  input  logic [SPI_BYTE_W-1:0]            i_RX_Byte,
  input  logic [SPI_BYTE_W-1:0]            i_Cmd
);

  localparam int unsigned WORD_W = SPI_BYTE_W * WORD_BYTES;
  localparam int unsigned CNT_W  = $clog2(WORD_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES);

  framer_state_e         state, state_next;
  logic [WORD_W-1:0]     tx_sr, tx_sr_next;
  logic [WORD_W-1:0]     rx_sr, rx_sr_next;
  logic [WORD_W-1:0]     word_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [SPI_BYTE_W-1:0] tx_byte_next;

`ifdef SPI_FRAMER_HDR_EN
  // Set while the header byte is the transfer in flight; the counter only
  // tracks payload bytes so it never needs to exceed WORD_BYTES.
  logic hdr_pend, hdr_pend_next;
`else
  logic unused_cmd;
  assign unused_cmd = ^i_Cmd;
`endif

  // Byte-valid depends on the live ready input so the pulse stays inside LOAD.
  assign o_TX_DV = (state == ST_LOAD) && i_TX_Ready;

  // Next-state and datapath update
  always_comb begin
    state_next   = state;
    tx_sr_next   = tx_sr;
    rx_sr_next   = rx_sr;
    cnt_next     = cnt;
    word_next    = o_Word;
    tx_byte_next = o_TX_Byte;
`ifdef SPI_FRAMER_HDR_EN
    hdr_pend_next = hdr_pend;
`endif
    unique case (state)
      ST_IDLE: begin
        if (i_Word_DV) begin
          state_next = ST_LOAD;
          tx_sr_next = i_Word;
          rx_sr_next = '0;
          cnt_next   = '0;
`ifdef SPI_FRAMER_HDR_EN
          hdr_pend_next = 1'b1;
          tx_byte_next  = i_Cmd;
`else
          tx_byte_next  = i_Word[WORD_W-1 -: SPI_BYTE_W];
`endif
        end
      end
      ST_LOAD: begin
        if (i_TX_Ready) state_next = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        if (i_RX_DV) begin
`ifdef SPI_FRAMER_HDR_EN
          if (hdr_pend) begin
            hdr_pend_next = 1'b0;
            state_next    = ST_LOAD;
            tx_byte_next  = tx_sr[WORD_W-1 -: SPI_BYTE_W];
          end else
`endif
          begin
            rx_sr_next = {rx_sr[WORD_W-SPI_BYTE_W-1:0], i_RX_Byte};
            tx_sr_next = {tx_sr[WORD_W-SPI_BYTE_W-1:0], {SPI_BYTE_W{1'b0}}};
            cnt_next   = cnt + CNT_W'(1);
            if (cnt_next == LAST_CNT) begin
              state_next = ST_DONE;
              word_next  = rx_sr_next;
            end else begin
              state_next   = ST_LOAD;
              tx_byte_next = tx_sr_next[WORD_W-1 -: SPI_BYTE_W];
            end
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= ST_IDLE;
      tx_sr        <= '0;
      rx_sr        <= '0;
      cnt          <= '0;
      o_Word       <= '0;
      o_TX_Byte    <= '0;
      o_Word_DV    <= 1'b0;
      o_Busy       <= 1'b0;
      o_Word_Ready <= 1'b1;
`ifdef SPI_FRAMER_HDR_EN
      hdr_pend     <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      tx_sr        <= tx_sr_next;
      rx_sr        <= rx_sr_next;
      cnt          <= cnt_next;
      o_Word       <= word_next;
      o_TX_Byte    <= tx_byte_next;
      o_Word_DV    <= (state_next == ST_DONE);
      o_Busy       <= (state_next != ST_IDLE);
      o_Word_Ready <= (state_next == ST_IDLE);
`ifdef SPI_FRAMER_HDR_EN
      hdr_pend     <= hdr_pend_next;
`endif
    end
  end

endmodule

// File: doc/spi_word_framer.md
SPI_WORD_FRAMER -- requirements
Module: spi_word_framer

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 8, the number of payload bytes per word (range 2..16).
REQ-002 SHALL have input i_Clk, 1 bit, the system clock.
REQ-003 SHALL have input i_Rst_L, 1 bit, the reset: asynchronous, active-low.
REQ-004 SHALL have input i_Word, 8*WORD_BYTES bits, the word to transmit.
REQ-005 SHALL have input i_Word_DV, 1 bit, the word-valid request.
REQ-006 SHALL have output o_Word_Ready, 1 bit, high when a new word can be accepted.
REQ-007 SHALL have output o_Word, 8*WORD_BYTES bits, the word received on MISO.
REQ-008 SHALL have output o_Word_DV, 1 bit, a one-cycle pulse when o_Word is valid.
REQ-009 SHALL have output o_Busy, 1 bit, high while a frame is in progress.
REQ-010 SHALL have output o_TX_Byte, 8 bits, the byte sent to the SPI byte stage.
REQ-011 SHALL have output o_TX_DV, 1 bit, the byte-valid pulse to the SPI byte stage.
REQ-012 SHALL have input i_TX_Ready, 1 bit, high when the SPI byte stage can accept a byte.
REQ-013 SHALL have input i_RX_DV, 1 bit, the byte-received pulse from the SPI byte stage.
REQ-014 SHALL have input i_RX_Byte, 8 bits, the received byte, valid when i_RX_DV is high.
REQ-015 SHALL have input i_Cmd, 8 bits, the header byte (used only with SPI_FRAMER_HDR_EN).

Function
REQ-016 SHALL use an FSM with states IDLE, LOAD, WAIT_RX and DONE.
REQ-017 SHALL drive o_Word_Ready high only in IDLE; a word SHALL be accepted when i_Word_DV and o_Word_Ready are both high.
REQ-018 On acceptance, SHALL latch i_Word (and i_Cmd), clear the byte counter and the RX shift register, and go to LOAD in the next cycle.
REQ-019 In LOAD, SHALL drive o_TX_Byte from the current byte and pulse o_TX_DV for exactly one cycle only when i_TX_Ready is high, then go to WAIT_RX.
REQ-020 SHALL send bytes MSB first: byte WORD_BYTES-1 (bits [8*WORD_BYTES-1 -: 8]) first, byte 0 last.
REQ-021 In WAIT_RX, on i_RX_DV, SHALL shift i_RX_Byte into the LSB end of the RX register and increment the counter.
REQ-022 After that shift, SHALL go to DONE if the last byte has been received, otherwise back to LOAD.
REQ-023 SHALL ignore i_RX_DV in IDLE and LOAD; o_TX_DV SHALL never be asserted outside LOAD.
REQ-024 In DONE, SHALL present o_Word (first received byte in the MSB), pulse o_Word_DV for one cycle, and return to IDLE in the next cycle.
REQ-025 o_Word SHALL hold its value until the next DONE.
REQ-026 SHALL ignore i_Word_DV outside IDLE; a new word SHALL be accepted no earlier than the cycle after DONE.
REQ-027 Latency SHALL be: first o_TX_DV no earlier than 1 cycle after acceptance; o_Word_DV exactly 1 cycle after the last i_RX_DV.
REQ-028 The byte counter SHALL be $clog2(WORD_BYTES+1) bits wide and SHALL NOT wrap within a frame.
REQ-029 o_Busy SHALL be high in every state except IDLE.

Reset
REQ-030 Reset assertion SHALL force state IDLE at any time, including mid-frame, and abort any frame in progress with no o_Word_DV.
REQ-031 During reset: o_TX_DV=0, o_Word_DV=0, o_TX_Byte=0, o_Word=0, o_Busy=0, and the counter and shift registers SHALL be 0.
REQ-032 o_Word_Ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-033 With macro SPI_FRAMER_HDR_EN defined, SHALL send the latched i_Cmd as one extra first byte, making WORD_BYTES+1 transfers.
REQ-034 With SPI_FRAMER_HDR_EN defined, the RX byte received during the header transfer SHALL be discarded and o_Word SHALL contain only the payload bytes.
REQ-035 Without SPI_FRAMER_HDR_EN, i_Cmd SHALL be unused and exactly WORD_BYTES transfers SHALL occur.

Structure
REQ-036 Package spi_pkg SHALL hold the framer state enum typedef (2-bit), the SPI_BYTE_W=8 constant and the default WORD_BYTES constant.
REQ-037 The design SHALL be a single module with no sub-module; the SPI byte stage SHALL be connected externally by the parent.

Verification
REQ-038 WORD_BYTES=8, MISO loopback, i_Word=64'h0123456789ABCDEF -> TX bytes 01,23,..,EF in order; o_Word=64'h0123456789ABCDEF; one o_Word_DV pulse.
REQ-039 i_TX_Ready held low for 20 cycles after acceptance -> no o_TX_DV until i_TX_Ready rises, then exactly one o_TX_DV pulse.
REQ-040 i_Word_DV held high continuously -> o_Word_Ready low from acceptance until after DONE; no word accepted mid-frame.
REQ-041 i_Rst_L pulsed low after the 3rd i_RX_DV -> IDLE, all outputs 0, no o_Word_DV; the next word completes normally.
REQ-042 SPI_FRAMER_HDR_EN defined, i_Cmd=8'hA5 -> 9 transfers with A5 first; o_Word holds only the 8 payload RX bytes.
REQ-043 i_RX_DV pulsed in IDLE and in LOAD -> RX register and counter unchanged.
